// File: rtl/shift_pkg.sv
// Shared encodings, FSM state type and parameter sanity check for the shift/rotate unit.
// Latency: none (declarations only).
// Backpressure: not applicable.
package shift_pkg;

    localparam logic [2:0] OP_SHL  = 3'b000;
    localparam logic [2:0] OP_SHR  = 3'b001;
    localparam logic [2:0] OP_SHRA = 3'b010;
    localparam logic [2:0] OP_ROL  = 3'b011;
    localparam logic [2:0] OP_ROR  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Codes above OP_ROR move the operand through untouched.
    function automatic logic isPassOp(input logic [2:0] opCode);
        return opCode > OP_ROR;
    endfunction

    // STEP must be a power of two no larger than half the word, so the
    // per-cycle mux chain never has to wrap a full word.
    function automatic bit stepOk(input int width, input int step);
        return (step >= 1) && ((step & (step - 1)) == 0) && (step <= width / 2);
    endfunction

endpackage

// File: rtl/shift_step.sv
// Moves a word by n bits (1..STEP) in the direction and fill mode selected by op.
// Latency: purely combinational, log2(STEP)+1 mux stages.
// Backpressure: none; output follows inputs.
module shift_step
    import shift_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int STEP  = 1,
    localparam int NW    = $clog2(STEP) + 1
) (
    input  logic [WIDTH-1:0] din,
    input  logic [2:0]       op,
    input  logic [NW-1:0]    n,
    input  logic             sign,
    output logic [WIDTH-1:0] dout
);

    // stage[k] holds the word after the low k bits of n have been applied.
    logic [WIDTH-1:0] stage [NW+1];

    assign stage[0] = din;

    for (genvar k = 0; k < NW; k++) begin : gStage
        localparam int K = 1 << k;

        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] moved;

        assign cur = stage[k];

        // Fixed move by 2^k bits in the selected mode.
        always_comb begin
            moved = cur;
            case (op)
                OP_SHL:  moved = cur << K;
                OP_SHR:  moved = cur >> K;
                OP_SHRA: moved = {{K{sign}}, cur[WIDTH-1:K]};
                OP_ROL:  moved = {cur[WIDTH-K-1:0], cur[WIDTH-1:WIDTH-K]};
                OP_ROR:  moved = {cur[K-1:0], cur[WIDTH-1:K]};
                default: moved = cur;
            endcase
        end

        assign stage[k+1] = n[k] ? moved : cur;
    end

    assign dout = stage[NW];

endmodule

// File: rtl/shift_rotate_unit.sv
// Multi-cycle shift/rotate unit (SHL, SHR, SHRA, ROL, ROR) moving up to STEP bits per cycle.
// Latency: ceil(shamt/STEP) cycles after the start edge; zero for shamt==0 or pass-through.
// Backpressure: start ignored while busy; done pulses one cycle, a new start is taken in that cycle.
module shift_rotate_unit
    import shift_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH),
    parameter int STEP    = 1
) (
    input  logic               clock,
    input  logic               clear_n,
    input  logic               start,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   z
);

    localparam int NW = $clog2(STEP) + 1;
    localparam logic [SHAMT_W-1:0] STEP_AMT = SHAMT_W'(STEP);

    if (!stepOk(WIDTH, STEP)) begin : gBadStep
        $error("shift_rotate_unit: STEP must be a power of two and at most WIDTH/2");
    end

    state_t             state;
    state_t             stateNext;
    logic [2:0]         opReg;
    logic [WIDTH-1:0]   work;
    logic               sign;
    logic [SHAMT_W-1:0] rem;
    logic [SHAMT_W-1:0] remNext;
    logic [NW-1:0]      nStep;
    logic [WIDTH-1:0]   stepped;
    logic               accept;
    logic               immediate;

    // A request is only looked at outside RUN; zero amounts and pass-through finish at once.
    assign accept    = (state != RUN) && start;
    assign immediate = (shamt == '0) || isPassOp(op);

    // Bits moved this cycle: the full STEP until the remainder is smaller.
    assign nStep   = (rem < STEP_AMT) ? rem[NW-1:0] : STEP_AMT[NW-1:0];
    assign remNext = rem - SHAMT_W'(nStep);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) uStep (
        .din  (work),
        .op   (opReg),
        .n    (nStep),
        .sign (sign),
        .dout (stepped)
    );

    // State register.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state: DONE lasts one cycle unless a new request arrives in it.
    always_comb begin
        stateNext = state;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stateNext = immediate ? DONE : RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            RUN: begin
                stateNext = (remNext == '0) ? DONE : RUN;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Operand capture, per-cycle stepping and result update.
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            opReg <= OP_SHL;
            work  <= '0;
            sign  <= 1'b0;
            rem   <= '0;
            z     <= '0;
        end else if (accept) begin
            opReg <= op;
            work  <= a;
            rem   <= shamt;
            sign  <= a[WIDTH-1];
            if (immediate) begin
                z <= a;
            end
        end else if (state == RUN) begin
            work <= stepped;
            rem  <= remNext;
            if (remNext == '0) begin
                z <= stepped;
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule

// File: tb/tb_shift_rotate_unit.sv
module tb_shift_rotate_unit;

    logic        clock = 1'b0;
    logic        clearN;
    logic        start [2];
    logic [2:0]  op    [2];
    logic [31:0] a     [2];
    logic [4:0]  shamt [2];
    logic        busy  [2];
    logic        done  [2];
    logic [31:0] z     [2];

    int nChecks = 0;
    int nFails  = 0;

    logic [31:0] q0 [$];
    logic [31:0] q1 [$];

    always #5 clock = ~clock;

    shift_rotate_unit #(.WIDTH(32), .STEP(1)) uStep1 (
        .clock   (clock),
        .clear_n (clearN),
        .start   (start[0]),
        .op      (op[0]),
        .a       (a[0]),
        .shamt   (shamt[0]),
        .busy    (busy[0]),
        .done    (done[0]),
        .z       (z[0])
    );

    shift_rotate_unit #(.WIDTH(32), .STEP(4)) uStep4 (
        .clock   (clock),
        .clear_n (clearN),
        .start   (start[1]),
        .op      (op[1]),
        .a       (a[1]),
        .shamt   (shamt[1]),
        .busy    (busy[1]),
        .done    (done[1]),
        .z       (z[1])
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFails++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Reference: one combinational shift/rotate by the full amount.
    function automatic logic [31:0] refModel(input logic [2:0] o, input logic [31:0] v, input int s);
        case (o)
            3'd0: return v << s;
            3'd1: return v >> s;
            3'd2: return $signed(v) >>> s;
            3'd3: return (s == 0) ? v : ((v << s) | (v >> (32 - s)));
            3'd4: return (s == 0) ? v : ((v >> s) | (v << (32 - s)));
            default: return v;
        endcase
    endfunction

    function automatic int expLatency(input logic [2:0] o, input int s, input int step);
        if (s == 0 || o > 3'd4) return 0;
        return (s + step - 1) / step;
    endfunction

    // Called at a negedge: present the request, push its expected result, let one edge sample it.
    task automatic issue(input int idx, input logic [2:0] o, input logic [31:0] v, input logic [4:0] s);
        logic [31:0] e;
        e = refModel(o, v, int'(s));
        if (idx == 0) q0.push_back(e); else q1.push_back(e);
        start[idx] = 1'b1;
        op[idx]    = o;
        a[idx]     = v;
        shamt[idx] = s;
        @(posedge clock);
        #1;
        start[idx] = 1'b0;
    endtask

    // Count cycles until done; optionally scramble inputs and pulse start while busy.
    task automatic waitDone(input int idx, input int expL, input bit disturb);
        int lat;
        int busyC;
        lat = 0;
        busyC = 0;
        @(negedge clock);
        while (!done[idx] && lat < 200) begin
            if (busy[idx]) begin
                busyC++;
                if (disturb) begin
                    start[idx] = 1'($urandom_range(0, 1));
                    a[idx]     = $urandom;
                    op[idx]    = 3'($urandom_range(0, 7));
                    shamt[idx] = 5'($urandom_range(0, 31));
                end
            end
            @(negedge clock);
            lat++;
        end
        start[idx] = 1'b0;
        check($sformatf("latency%0d", idx), lat, expL);
        check($sformatf("busyCycles%0d", idx), busyC, expL);
    endtask

    task automatic runOp(input int idx, input logic [2:0] o, input logic [31:0] v,
                         input logic [4:0] s, input bit disturb);
        issue(idx, o, v, s);
        waitDone(idx, expLatency(o, int'(s), (idx == 0) ? 1 : 4), disturb);
    endtask

    // Scoreboard monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (clearN === 1'b1 && done[0] === 1'b1) begin
            if (q0.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpectedDone0: got done=1 with z=%h, required no pulse", z[0]);
            end else begin
                check("z0", z[0], q0.pop_front());
            end
        end
        if (clearN === 1'b1 && done[1] === 1'b1) begin
            if (q1.size() == 0) begin
                nChecks++;
                nFails++;
                $display("FAIL unexpectedDone1: got done=1 with z=%h, required no pulse", z[1]);
            end else begin
                check("z1", z[1], q1.pop_front());
            end
        end
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            start[i] = 1'b0;
            op[i]    = 3'd0;
            a[i]     = 32'd0;
            shamt[i] = 5'd0;
        end
        clearN = 1'b0;
        repeat (3) @(negedge clock);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("resetBusy%0d", i), 32'(busy[i]), 32'd0);
            check($sformatf("resetDone%0d", i), 32'(done[i]), 32'd0);
            check($sformatf("resetZ%0d", i), z[i], 32'd0);
        end
        clearN = 1'b1;
        repeat (2) @(negedge clock);

        // Directed cases, STEP=1
        runOp(0, 3'd3, 32'hF000_0000, 5'd4, 1'b0);
        runOp(0, 3'd3, 32'h4000_0000, 5'd3, 1'b0);
        @(negedge clock);
        runOp(0, 3'd2, 32'h8000_0000, 5'd31, 1'b0);
        runOp(0, 3'd1, 32'h8000_0000, 5'd31, 1'b0);
        runOp(0, 3'd0, 32'h0000_0001, 5'd31, 1'b0);
        runOp(0, 3'd4, 32'h0000_0001, 5'd1, 1'b0);
        runOp(0, 3'd3, 32'h1234_5678, 5'd0, 1'b0);
        runOp(0, 3'd6, 32'h1234_5678, 5'd7, 1'b0);
        check("holdZ0", z[0], 32'h1234_5678);
        runOp(0, 3'd4, 32'hDEAD_BEEF, 5'd13, 1'b1);

        // Directed cases, STEP=4, second one back-to-back in the DONE cycle
        runOp(1, 3'd3, 32'h0000_0001, 5'd5, 1'b0);
        runOp(1, 3'd4, 32'h0000_0020, 5'd8, 1'b0);
        @(negedge clock);
        runOp(1, 3'd2, 32'h8765_4321, 5'd17, 1'b1);

        // Randomised traffic on both widths of step
        for (int it = 0; it < 60; it++) begin
            int idx;
            idx = it % 2;
            runOp(idx, 3'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clock);
        end

        // Reset in the middle of a long operation
        issue(0, 3'd3, 32'hA5A5_0001, 5'd20);
        repeat (5) @(negedge clock);
        clearN = 1'b0;
        #1;
        check("midResetBusy", 32'(busy[0]), 32'd0);
        check("midResetDone", 32'(done[0]), 32'd0);
        check("midResetZ", z[0], 32'd0);
        q0.delete();
        @(negedge clock);
        clearN = 1'b1;
        begin
            int pulses;
            pulses = 0;
            repeat (25) begin
                @(negedge clock);
                if (done[0]) pulses++;
            end
            check("noDoneAfterReset", pulses, 0);
        end
        runOp(0, 3'd3, 32'h8000_0001, 5'd2, 1'b0);

        repeat (3) @(negedge clock);
        check("scoreboardEmpty0", q0.size(), 0);
        check("scoreboardEmpty1", q1.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
